// File: rtl/pauli_frame_engine_pkg.sv
// pauli_frame_pkg: shared types and single-qubit Clifford update for pauli_frame_engine
package pauli_frame_pkg;
  typedef struct packed {
    logic z;
    logic x;
  } pauli_t;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_XOR  = 3'd1,
    OP_SET  = 3'd2,
    OP_H    = 3'd3,
    OP_S    = 3'd4,
    OP_CNOT = 3'd5
  } pf_op_e;
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_state_e;
  function automatic pauli_t clifford_apply(pf_op_e op, pauli_t p, pauli_t operand);
    return op == OP_XOR ? pauli_t'(p ^ operand) :
           op == OP_SET ? operand :
           op == OP_H   ? pauli_t'({p.x, p.z}) :
           op == OP_S   ? pauli_t'({p.z ^ p.x, p.x}) : p;
  endfunction
  function automatic logic uses_a(pf_op_e op);
    return op inside {OP_XOR, OP_SET, OP_H, OP_S, OP_CNOT};
  endfunction
endpackage

// File: rtl/pauli_frame_engine_if.sv
// pauli_frame_engine_if: command, read, measurement and clear bundle; APEX_FRAME_PARITY_EN adds parity_inj/parity_err
interface pauli_frame_engine_if #(
  parameter int NUM_LANES = 2,
  parameter int NUM_RD    = 2,
  parameter int ADDR_W    = 6
);
  logic [NUM_LANES-1:0]        cmd_valid;
  logic [NUM_LANES-1:0]        cmd_ready;
  logic [3*NUM_LANES-1:0]      cmd_op;
  logic [ADDR_W*NUM_LANES-1:0] cmd_addr_a;
  logic [ADDR_W*NUM_LANES-1:0] cmd_addr_b;
  logic [2*NUM_LANES-1:0]      cmd_pauli;
  logic [ADDR_W*NUM_RD-1:0]    rd_addr;
  logic [2*NUM_RD-1:0]         rd_pauli;
  logic                        meas_valid;
  logic [ADDR_W-1:0]           meas_addr;
  logic                        meas_basis;
  logic                        meas_raw;
  logic                        meas_out_valid;
  logic                        meas_out;
  logic                        clr_req;
  logic                        busy;
  logic                        clr_done;
`ifdef APEX_FRAME_PARITY_EN
  logic                        parity_inj;
  logic                        parity_err;
  modport master (
    output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_pauli, rd_addr,
           meas_valid, meas_addr, meas_basis, meas_raw, clr_req, parity_inj,
    input  cmd_ready, rd_pauli, meas_out_valid, meas_out, busy, clr_done, parity_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_pauli, rd_addr,
           meas_valid, meas_addr, meas_basis, meas_raw, clr_req, parity_inj,
    output cmd_ready, rd_pauli, meas_out_valid, meas_out, busy, clr_done, parity_err
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_pauli, rd_addr,
           meas_valid, meas_addr, meas_basis, meas_raw, clr_req,
    input  cmd_ready, rd_pauli, meas_out_valid, meas_out, busy, clr_done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_pauli, rd_addr,
           meas_valid, meas_addr, meas_basis, meas_raw, clr_req,
    output cmd_ready, rd_pauli, meas_out_valid, meas_out, busy, clr_done
  );
`endif
endinterface

// File: rtl/pauli_frame_engine_arb.sv
// pf_hazard_arbiter: per-lane ready; a lane stalls if its address set meets any valid lower lane's set
module pf_hazard_arbiter
  import pauli_frame_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int ADDR_W    = 6
) (
  input  logic                        en,
  input  logic [NUM_LANES-1:0]        valid,
  input  logic [3*NUM_LANES-1:0]      op,
  input  logic [ADDR_W*NUM_LANES-1:0] addr_a,
  input  logic [ADDR_W*NUM_LANES-1:0] addr_b,
  output logic [NUM_LANES-1:0]        ready
);
  logic [NUM_LANES-1:0] ha, hb;
  logic [ADDR_W-1:0]    a [NUM_LANES];
  logic [ADDR_W-1:0]    b [NUM_LANES];
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      ha[i] = uses_a(pf_op_e'(op[3*i +: 3]));
      hb[i] = pf_op_e'(op[3*i +: 3]) == OP_CNOT;
      a[i]  = addr_a[ADDR_W*i +: ADDR_W];
      b[i]  = addr_b[ADDR_W*i +: ADDR_W];
    end
  end
  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ready[i] = en;
      for (int j = 0; j < i; j++)
        if (valid[j] && ((ha[i] && ha[j] && a[i] == a[j]) || (ha[i] && hb[j] && a[i] == b[j]) ||
                         (hb[i] && ha[j] && b[i] == a[j]) || (hb[i] && hb[j] && b[i] == b[j])))
          ready[i] = 1'b0;
    end
  end
endmodule

// File: rtl/pauli_frame_engine.sv
// pauli_frame_engine: multi-lane Pauli frame tracker with bulk clear; define APEX_FRAME_PARITY_EN for per-entry parity
module pauli_frame_engine
  import pauli_frame_pkg::*;
#(
  parameter int NUM_QUBITS    = 49,
  parameter int NUM_LANES     = 2,
  parameter int NUM_RD        = 2,
  parameter int CLR_PER_CYCLE = 8,
  parameter int ADDR_W        = $clog2(NUM_QUBITS)
) (
  input logic                 clk,
  input logic                 rst,
  pauli_frame_engine_if.slave bus
);
  localparam int NCHUNK = (NUM_QUBITS + CLR_PER_CYCLE - 1) / CLR_PER_CYCLE;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_QUBITS - 1);
  pauli_t [NUM_QUBITS-1:0] mem, mem_d;
  fsm_state_e              state_q, state_d;
  logic [CW-1:0]           chunk_q, chunk_d;
  logic                    last, done_d;
  logic [NUM_QUBITS-1:0]   clr_hit;
  logic [NUM_LANES-1:0]    we_a, we_b;
  pf_op_e                  op   [NUM_LANES];
  logic [ADDR_W-1:0]       wa_a [NUM_LANES];
  logic [ADDR_W-1:0]       wa_b [NUM_LANES];
  pauli_t                  pa   [NUM_LANES];
  pauli_t                  pb   [NUM_LANES];
  pauli_t                  wd_a [NUM_LANES];
  pauli_t                  wd_b [NUM_LANES];
  logic [ADDR_W-1:0]       rda  [NUM_RD];
  pauli_t                  mf;
  pf_hazard_arbiter #(.NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W)) u_arb (
    .en    (state_q == IDLE && !bus.clr_req && !rst),
    .valid (bus.cmd_valid),
    .op    (bus.cmd_op),
    .addr_a(bus.cmd_addr_a),
    .addr_b(bus.cmd_addr_b),
    .ready (bus.cmd_ready)
  );
  always_comb begin
    last    = chunk_q == CW'(NCHUNK - 1);
    state_d = state_q == IDLE ? (bus.clr_req ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    chunk_d = (state_q == CLEAR && !last) ? chunk_q + 1'b1 : '0;
    done_d  = state_q == CLEAR && last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      chunk_q      <= '0;
      bus.clr_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      chunk_q      <= chunk_d;
      bus.clr_done <= done_d;
    end
  assign bus.busy = state_q == CLEAR;
  always_comb
    for (int q = 0; q < NUM_QUBITS; q++)
      clr_hit[q] = state_q == CLEAR && chunk_q == CW'(q / CLR_PER_CYCLE);
  // Accepted lanes never share an address, so all updates read pre-cycle state independently
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      op[i]   = pf_op_e'(bus.cmd_op[3*i +: 3]);
      wa_a[i] = bus.cmd_addr_a[ADDR_W*i +: ADDR_W];
      wa_b[i] = bus.cmd_addr_b[ADDR_W*i +: ADDR_W];
      pa[i]   = wa_a[i] <= LAST ? mem[wa_a[i]] : '0;
      pb[i]   = wa_b[i] <= LAST ? mem[wa_b[i]] : '0;
      we_a[i] = bus.cmd_valid[i] && bus.cmd_ready[i] && wa_a[i] <= LAST &&
                (op[i] == OP_CNOT ? (wa_b[i] <= LAST && wa_a[i] != wa_b[i])
                                  : op[i] inside {OP_XOR, OP_SET, OP_H, OP_S});
      we_b[i] = we_a[i] && op[i] == OP_CNOT;
      wd_a[i] = op[i] == OP_CNOT ? pauli_t'({pa[i].z ^ pb[i].z, pa[i].x})
                                 : clifford_apply(op[i], pa[i], pauli_t'(bus.cmd_pauli[2*i +: 2]));
      wd_b[i] = pauli_t'({pb[i].z, pb[i].x ^ pa[i].x});
    end
  end
  always_comb begin
    mem_d = mem;
    for (int q = 0; q < NUM_QUBITS; q++)
      if (clr_hit[q]) mem_d[q] = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we_a[i]) mem_d[wa_a[i]] = wd_a[i];
      if (we_b[i]) mem_d[wa_b[i]] = wd_b[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '0;
    else     mem <= mem_d;
  always_comb begin
    bus.rd_pauli = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rda[r] = bus.rd_addr[ADDR_W*r +: ADDR_W];
      bus.rd_pauli[2*r +: 2] = rda[r] <= LAST ? mem[rda[r]] : '0;
    end
  end
  assign mf = bus.meas_addr <= LAST ? mem[bus.meas_addr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.meas_out_valid <= 1'b0;
      bus.meas_out       <= 1'b0;
    end else begin
      bus.meas_out_valid <= bus.meas_valid;
      if (bus.meas_valid) bus.meas_out <= bus.meas_raw ^ (bus.meas_basis ? mf.z : mf.x);
    end
`ifdef APEX_FRAME_PARITY_EN
  logic [NUM_QUBITS-1:0] par, par_d;
  logic                  perr_hit;
  // Stored bit equals z^x so a healthy entry has even parity over all three bits
  always_comb begin
    par_d = par;
    for (int q = 0; q < NUM_QUBITS; q++)
      if (clr_hit[q]) par_d[q] = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we_a[i]) par_d[wa_a[i]] = ^wd_a[i] ^ (i == 0 && bus.parity_inj);
      if (we_b[i]) par_d[wa_b[i]] = ^wd_b[i] ^ (i == 0 && bus.parity_inj);
    end
  end
  always_comb begin
    perr_hit = bus.meas_valid && bus.meas_addr <= LAST && (^mem[bus.meas_addr] != par[bus.meas_addr]);
    for (int r = 0; r < NUM_RD; r++)
      if (rda[r] <= LAST && (^mem[rda[r]] != par[rda[r]])) perr_hit = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par            <= '0;
      bus.parity_err <= 1'b0;
    end else begin
      par            <= par_d;
      bus.parity_err <= done_d ? 1'b0 : bus.parity_err | perr_hit;
    end
`endif
endmodule
